// File: rtl/image_mem_arbiter.sv
// image_mem_arbiter
// Arbitrates a single-port sprite image memory between the VGA display read
// path and the HPS loader write path. Reads normally win; writes are buffered
// in an in-order queue and drained on idle cycles, or in a forced slot once
// reads have starved the queue for STARVE_LIMIT consecutive grants.
//
// Ports
//   clk50, reset                     clock, async active-high reset
//   wr_req/wr_addr/wr_data           loader write push
//   wr_full, wq_empty, overflow      queue status; overflow is sticky
//   clr_overflow                     clears overflow (a same-edge drop wins)
//   rd_req/rd_addr                   display read request
//   rd_gnt                           combinational read accept
//   rd_valid/rd_data                 read return, 2 cycles after accept
//   mem_a/mem_we/mem_din/mem_dout    registered sync-RAM port
//   arb_state                        op issued at last edge: 0 IDLE, 1 RD, 2 WR
//
// state  | meaning
// IDLE   | no memory operation issued
// RD     | display read issued to memory
// WR     | queue head written to memory
module image_mem_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 24,
  parameter int WQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  output logic              wq_empty,
  output logic              overflow,
  input  logic              clr_overflow,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        arb_state
);

  localparam int PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(WQ_DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } op_t;

  op_t op_q, op_next;

  logic [ADDR_W-1:0] wq_addr [WQ_DEPTH];
  logic [DATA_W-1:0] wq_data [WQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  wq_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              push, pop, force_wr;
  logic              rd_pipe1, rd_pipe2;

  assign wq_empty = (wq_cnt == '0);
  assign wr_full  = (wq_cnt == CNT_W'(WQ_DEPTH));
  assign push     = wr_req & ~wr_full;
  assign force_wr = (starve_cnt == SC_W'(STARVE_LIMIT)) & ~wq_empty;
  assign rd_gnt   = rd_req & ~force_wr;
  assign pop      = (op_next == ST_WR);
  assign arb_state = op_q;

  // A push this edge is not visible to the issue decision until the next
  // edge, since wq_empty reflects the registered count.
  always_comb begin
    op_next = ST_IDLE;
    if (rd_gnt)
      op_next = ST_RD;
    else if (!wq_empty)
      op_next = ST_WR;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) op_q <= ST_IDLE;
    else       op_q <= op_next;
  end

  // Queue storage holds no observable state while empty, so it needs no reset.
  always_ff @(posedge clk50) begin
    if (push) begin
      wq_addr[wr_ptr] <= wr_addr;
      wq_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wq_cnt     <= '0;
      starve_cnt <= '0;
      overflow   <= 1'b0;
      mem_a      <= '0;
      mem_we     <= 1'b0;
      mem_din    <= '0;
      rd_pipe1   <= 1'b0;
      rd_pipe2   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   wq_cnt <= wq_cnt + CNT_W'(1);
        2'b01:   wq_cnt <= wq_cnt - CNT_W'(1);
        default: wq_cnt <= wq_cnt;
      endcase

      if (wr_req && wr_full) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;

      if (wq_empty || pop)
        starve_cnt <= '0;
      else if (rd_gnt && starve_cnt != SC_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SC_W'(1);

      mem_we <= 1'b0;
      case (op_next)
        ST_RD: mem_a <= rd_addr;
        ST_WR: begin
          mem_a   <= wq_addr[rd_ptr];
          mem_din <= wq_data[rd_ptr];
          mem_we  <= 1'b1;
        end
        default: ;
      endcase

      // mem_dout is valid one cycle after the RAM samples mem_a.
      rd_pipe1 <= (op_next == ST_RD);
      rd_pipe2 <= rd_pipe1;
      rd_valid <= rd_pipe2;
      if (rd_pipe2) rd_data <= mem_dout;
    end
  end

endmodule

// File: tb/tb_image_mem_arbiter.sv
module tb_image_mem_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 24;

  logic              clk50 = 1'b0;
  logic              reset;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full, wq_empty, overflow;
  logic              clr_overflow;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic [1:0]        arb_state;

  logic              preload;
  logic [DATA_W-1:0] ram [256];

  int n_cmp = 0;
  int n_err = 0;

  image_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WQ_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk50(clk50), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_full(wr_full), .wq_empty(wq_empty), .overflow(overflow), .clr_overflow(clr_overflow),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_a(mem_a), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .arb_state(arb_state)
  );

  always #10 clk50 = ~clk50;

  // Synchronous RAM: word at address a preloads to {C3, a, ~a}.
  always @(posedge clk50) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= {8'hC3, 8'(i), ~8'(i)};
      mem_dout <= '0;
    end else begin
      if (mem_we) ram[mem_a[7:0]] <= mem_din;
      mem_dout <= ram[mem_a[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic idle_inputs();
    wr_req = 0; wr_addr = '0; wr_data = '0; clr_overflow = 0; rd_req = 0; rd_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; preload = 1;
    tick(); tick();
    preload = 0; reset = 0;
    #1;
    if (wq_empty !== 1'b1) begin $display("FAIL reset_wq_empty: got %b want 1", wq_empty); n_err++; end n_cmp++;
    if (wr_full !== 1'b0) begin $display("FAIL reset_wr_full: got %b want 0", wr_full); n_err++; end n_cmp++;
    if (overflow !== 1'b0) begin $display("FAIL reset_overflow: got %b want 0", overflow); n_err++; end n_cmp++;
    if (mem_we !== 1'b0) begin $display("FAIL reset_mem_we: got %b want 0", mem_we); n_err++; end n_cmp++;
    if (mem_a !== 20'h0) begin $display("FAIL reset_mem_a: got %h want 0", mem_a); n_err++; end n_cmp++;
    if (mem_din !== 24'h0) begin $display("FAIL reset_mem_din: got %h want 0", mem_din); n_err++; end n_cmp++;
    if (rd_valid !== 1'b0) begin $display("FAIL reset_rd_valid: got %b want 0", rd_valid); n_err++; end n_cmp++;
    if (rd_data !== 24'h0) begin $display("FAIL reset_rd_data: got %h want 0", rd_data); n_err++; end n_cmp++;
    if (arb_state !== 2'd0) begin $display("FAIL reset_arb_state: got %0d want 0", arb_state); n_err++; end n_cmp++;
  endtask

  task automatic test_read_only();
    logic [DATA_W-1:0] exp_data [4];
    exp_data[0] = 24'hC310EF; exp_data[1] = 24'hC311EE;
    exp_data[2] = 24'hC312ED; exp_data[3] = 24'hC313EC;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin rd_req = 1; rd_addr = 20'h00010 + 20'(k); end
      else rd_req = 0;
      #1;
      if (k < 4) begin
        if (rd_gnt !== 1'b1) begin $display("FAIL rd_gnt[%0d]: got %b want 1", k, rd_gnt); n_err++; end n_cmp++;
      end
      tick();
      if (k < 4) begin
        if (mem_a !== 20'h00010 + 20'(k)) begin $display("FAIL rd_mem_a[%0d]: got %h want %h", k, mem_a, 20'h00010 + 20'(k)); n_err++; end n_cmp++;
        if (mem_we !== 1'b0) begin $display("FAIL rd_mem_we[%0d]: got %b want 0", k, mem_we); n_err++; end n_cmp++;
        if (arb_state !== 2'd1) begin $display("FAIL rd_arb_state[%0d]: got %0d want 1", k, arb_state); n_err++; end n_cmp++;
      end
      if (rd_valid !== (k >= 2 && k <= 5)) begin $display("FAIL rd_valid[%0d]: got %b want %b", k, rd_valid, (k >= 2 && k <= 5)); n_err++; end n_cmp++;
      if (k >= 2 && k <= 5) begin
        if (rd_data !== exp_data[k-2]) begin $display("FAIL rd_data[%0d]: got %h want %h", k, rd_data, exp_data[k-2]); n_err++; end n_cmp++;
      end
    end
  endtask

  task automatic test_starvation();
    do_reset();
    wr_req = 1; wr_addr = 20'h00020; wr_data = 24'hABCDEF;
    rd_req = 1; rd_addr = 20'h00030;
    #1;
    if (rd_gnt !== 1'b1) begin $display("FAIL starve_first_gnt: got %b want 1", rd_gnt); n_err++; end n_cmp++;
    tick();
    wr_req = 0;
    if (wq_empty !== 1'b0) begin $display("FAIL starve_queued: wq_empty got %b want 0", wq_empty); n_err++; end n_cmp++;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rd_gnt !== 1'b1) begin $display("FAIL starve_gnt[%0d]: got %b want 1", i, rd_gnt); n_err++; end n_cmp++;
      tick();
      if (arb_state !== 2'd1) begin $display("FAIL starve_rd_state[%0d]: got %0d want 1", i, arb_state); n_err++; end n_cmp++;
    end
    #1;
    if (rd_gnt !== 1'b0) begin $display("FAIL starve_forced_gnt: got %b want 0", rd_gnt); n_err++; end n_cmp++;
    tick();
    if (mem_we !== 1'b1) begin $display("FAIL starve_mem_we: got %b want 1", mem_we); n_err++; end n_cmp++;
    if (mem_a !== 20'h00020) begin $display("FAIL starve_mem_a: got %h want 00020", mem_a); n_err++; end n_cmp++;
    if (mem_din !== 24'hABCDEF) begin $display("FAIL starve_mem_din: got %h want abcdef", mem_din); n_err++; end n_cmp++;
    if (arb_state !== 2'd2) begin $display("FAIL starve_wr_state: got %0d want 2", arb_state); n_err++; end n_cmp++;
    #1;
    if (rd_gnt !== 1'b1) begin $display("FAIL starve_resume_gnt: got %b want 1", rd_gnt); n_err++; end n_cmp++;
    tick();
    if (arb_state !== 2'd1) begin $display("FAIL starve_resume_state: got %0d want 1", arb_state); n_err++; end n_cmp++;
    if (mem_we !== 1'b0) begin $display("FAIL starve_resume_we: got %b want 0", mem_we); n_err++; end n_cmp++;
    if (wq_empty !== 1'b1) begin $display("FAIL starve_drained: wq_empty got %b want 1", wq_empty); n_err++; end n_cmp++;
    rd_req = 0;
  endtask

  task automatic test_full_overflow_and_drain();
    do_reset();
    rd_req = 1; rd_addr = 20'h00031;
    for (int k = 0; k < 5; k++) begin
      wr_req = 1; wr_addr = 20'h00040 + 20'(k); wr_data = 24'hD00D00 + 24'(k);
      #1;
      if (wr_full !== (k == 4)) begin $display("FAIL full_pre[%0d]: got %b want %b", k, wr_full, (k == 4)); n_err++; end n_cmp++;
      tick();
      if (wr_full !== (k >= 3)) begin $display("FAIL full_post[%0d]: got %b want %b", k, wr_full, (k >= 3)); n_err++; end n_cmp++;
      if (overflow !== (k == 4)) begin $display("FAIL overflow[%0d]: got %b want %b", k, overflow, (k == 4)); n_err++; end n_cmp++;
    end
    // drop and clear on the same edge: the drop keeps overflow set
    wr_req = 1; wr_addr = 20'h000FF; clr_overflow = 1;
    tick();
    if (overflow !== 1'b1) begin $display("FAIL overflow_set_wins: got %b want 1", overflow); n_err++; end n_cmp++;
    wr_req = 0;
    tick();
    clr_overflow = 0;
    if (overflow !== 1'b0) begin $display("FAIL overflow_clear: got %b want 0", overflow); n_err++; end n_cmp++;
    if (wr_full !== 1'b1) begin $display("FAIL full_held: got %b want 1", wr_full); n_err++; end n_cmp++;

    // Idle drain; a push alongside the second pop joins the back of the queue.
    rd_req = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin wr_req = 1; wr_addr = 20'h00044; wr_data = 24'hD00D04; end
      else wr_req = 0;
      tick();
      if (mem_we !== 1'b1) begin $display("FAIL drain_we[%0d]: got %b want 1", k, mem_we); n_err++; end n_cmp++;
      if (mem_a !== 20'h00040 + 20'(k)) begin $display("FAIL drain_a[%0d]: got %h want %h", k, mem_a, 20'h00040 + 20'(k)); n_err++; end n_cmp++;
      if (mem_din !== 24'hD00D00 + 24'(k)) begin $display("FAIL drain_din[%0d]: got %h want %h", k, mem_din, 24'hD00D00 + 24'(k)); n_err++; end n_cmp++;
      if (arb_state !== 2'd2) begin $display("FAIL drain_state[%0d]: got %0d want 2", k, arb_state); n_err++; end n_cmp++;
      if (k == 1) begin
        if (wr_full !== 1'b0) begin $display("FAIL push_pop_full: got %b want 0", wr_full); n_err++; end n_cmp++;
      end
    end
    wr_req = 0;
    if (wq_empty !== 1'b1) begin $display("FAIL drain_empty: got %b want 1", wq_empty); n_err++; end n_cmp++;
    tick();
    if (arb_state !== 2'd0) begin $display("FAIL idle_state: got %0d want 0", arb_state); n_err++; end n_cmp++;
    if (mem_we !== 1'b0) begin $display("FAIL idle_we: got %b want 0", mem_we); n_err++; end n_cmp++;
    if (mem_a !== 20'h00044) begin $display("FAIL idle_a_held: got %h want 00044", mem_a); n_err++; end n_cmp++;
    if (mem_din !== 24'hD00D04) begin $display("FAIL idle_din_held: got %h want d00d04", mem_din); n_err++; end n_cmp++;

    // read back a drained word: the memory now holds the written value
    rd_req = 1; rd_addr = 20'h00042;
    tick();
    rd_req = 0;
    tick(); tick();
    if (rd_valid !== 1'b1) begin $display("FAIL readback_valid: got %b want 1", rd_valid); n_err++; end n_cmp++;
    if (rd_data !== 24'hD00D02) begin $display("FAIL readback_data: got %h want d00d02", rd_data); n_err++; end n_cmp++;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    rd_req = 1; rd_addr = 20'h00012;
    wr_req = 1; wr_addr = 20'h00050; wr_data = 24'h111111;
    tick();
    wr_addr = 20'h00051; wr_data = 24'h222222;
    tick();
    idle_inputs();
    reset = 1;
    #1;
    if (wq_empty !== 1'b1) begin $display("FAIL midrst_wq_empty: got %b want 1", wq_empty); n_err++; end n_cmp++;
    if (mem_we !== 1'b0) begin $display("FAIL midrst_mem_we: got %b want 0", mem_we); n_err++; end n_cmp++;
    if (mem_a !== 20'h0) begin $display("FAIL midrst_mem_a: got %h want 0", mem_a); n_err++; end n_cmp++;
    if (arb_state !== 2'd0) begin $display("FAIL midrst_state: got %0d want 0", arb_state); n_err++; end n_cmp++;
    if (rd_data !== 24'h0) begin $display("FAIL midrst_rd_data: got %h want 0", rd_data); n_err++; end n_cmp++;
    tick();
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rd_valid !== 1'b0) begin $display("FAIL postrst_rd_valid[%0d]: got %b want 0", k, rd_valid); n_err++; end n_cmp++;
      if (mem_we !== 1'b0) begin $display("FAIL postrst_mem_we[%0d]: got %b want 0", k, mem_we); n_err++; end n_cmp++;
      if (wq_empty !== 1'b1) begin $display("FAIL postrst_empty[%0d]: got %b want 1", k, wq_empty); n_err++; end n_cmp++;
      if (arb_state !== 2'd0) begin $display("FAIL postrst_state[%0d]: got %0d want 0", k, arb_state); n_err++; end n_cmp++;
    end
  endtask

  initial begin
    preload = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_read_only();
    test_starvation();
    test_full_overflow_and_drain();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
